cplx_frame_accumulator: RTL and testbench

Downstream consumer of the shared-multiplier complex product stage. Takes the 16-bit real/imag product words and accumulates FRAME_LEN accepted samples into wide signed sums, forming a complex dot product. At the end of each frame it presents the sums on a valid/ready output with a per-frame overflow flag. Feeds the result formatter/bus interface.

---
 rtl/cplx_pkg.sv | 39 +++
 rtl/cplx_sat_acc.sv | 39 +++
 rtl/cplx_frame_accumulator.sv | 109 ++++++++++
 tb/tb_cplx_frame_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// rtl/cplx_pkg.sv - shared widths, output FSM states and saturating add for the frame accumulator
package cplx_pkg;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_ACC_W = 24;
  localparam int SAT_W     = 64;

  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} fsm_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int w);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = a + b;
    hi = $signed((64'd1 << (w - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    sat_add.sum = s;
    sat_add.ovf = 1'b0;
    if (s > hi) begin
      sat_add.sum = hi;
      sat_add.ovf = 1'b1;
    end else if (s < lo) begin
      sat_add.sum = lo;
      sat_add.ovf = 1'b1;
    end
  endfunction

endpackage

// File: rtl/cplx_sat_acc.sv
// rtl/cplx_sat_acc.sv - one signed saturating accumulator with clear and frame restart
module cplx_sat_acc
  import cplx_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    add,
  input  logic                    restart,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] acc;
  sat_res_t                res;
  logic                    unused_hi;

  always_comb res = sat_add(SAT_W'(acc), SAT_W'(din), ACC_W);

  assign sum       = res.sum[ACC_W-1:0];
  assign ovf       = res.ovf;
  assign unused_hi = ^res.sum[SAT_W-1:ACC_W];

  // restart: the completing sample's sum leaves via the output register, so start from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add) begin
      acc <= restart ? '0 : sum;
    end
  end

endmodule

// File: rtl/cplx_frame_accumulator.sv
// rtl/cplx_frame_accumulator.sv - accumulates FRAME_LEN complex products into saturated sums
module cplx_frame_accumulator
  import cplx_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_real,
  input  logic [IN_W-1:0]  in_imag,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_real,
  output logic [ACC_W-1:0] out_imag,
  output logic             out_overflow,
  output logic [15:0]      sample_cnt
);

  localparam logic [15:0] LAST = 16'(FRAME_LEN - 1);

  logic                    last;
  logic                    accept;
  logic                    frame_end;
  logic                    sticky;
  logic                    ovf_r;
  logic                    ovf_i;
  logic signed [ACC_W-1:0] sum_r;
  logic signed [ACC_W-1:0] sum_i;
  fsm_t                    state;
  fsm_t                    state_nx;

  assign last      = (sample_cnt == LAST);
  // Only the completing sample needs the output slot, so only it waits on a held result.
  assign in_ready  = !(out_valid && !out_ready && last);
  assign accept    = in_valid && in_ready && !clear;
  assign frame_end = accept && last;
  assign out_valid = (state == FULL);

  cplx_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_real (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .add     (accept),
    .restart (frame_end),
    .din     (in_real),
    .sum     (sum_r),
    .ovf     (ovf_r)
  );

  cplx_sat_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_imag (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .add     (accept),
    .restart (frame_end),
    .din     (in_imag),
    .sum     (sum_i),
    .ovf     (ovf_i)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (frame_end) state_nx = FULL;
      FULL:    if (out_ready && !frame_end) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      sticky     <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      sticky     <= 1'b0;
    end else if (accept) begin
      sample_cnt <= last ? 16'd0 : sample_cnt + 16'd1;
      sticky     <= last ? 1'b0 : (sticky | ovf_r | ovf_i);
    end
  end

  // A pending result is untouched by clear; it only reloads on a frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_real     <= '0;
      out_imag     <= '0;
      out_overflow <= 1'b0;
    end else if (frame_end) begin
      out_real     <= sum_r;
      out_imag     <= sum_i;
      out_overflow <= sticky | ovf_r | ovf_i;
    end
  end

endmodule

// File: tb/tb_cplx_frame_accumulator.sv
// tb/tb_cplx_frame_accumulator.sv - directed self-checking bench for cplx_frame_accumulator
module tb_cplx_frame_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        d_v = 0, d_or = 0, d_clr = 0, d_ir, d_ov, d_oovf;
  logic [15:0] d_re = 0, d_im = 0, d_cnt;
  logic [23:0] d_orl, d_oim;

  logic        s_v = 0, s_or = 0, s_clr = 0, s_ir, s_ov, s_oovf;
  logic [15:0] s_re = 0, s_im = 0, s_cnt;
  logic [16:0] s_orl, s_oim;

  logic        o_v = 0, o_or = 0, o_clr = 0, o_ir, o_ov, o_oovf;
  logic [15:0] o_re = 0, o_im = 0, o_cnt;
  logic [23:0] o_orl, o_oim;

  int pass_cnt = 0;
  int total_cnt = 0;

  cplx_frame_accumulator #(.IN_W(16), .ACC_W(24), .FRAME_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(d_v), .in_ready(d_ir), .in_real(d_re), .in_imag(d_im),
    .clear(d_clr), .out_valid(d_ov), .out_ready(d_or), .out_real(d_orl), .out_imag(d_oim),
    .out_overflow(d_oovf), .sample_cnt(d_cnt)
  );

  cplx_frame_accumulator #(.IN_W(16), .ACC_W(17), .FRAME_LEN(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_v), .in_ready(s_ir), .in_real(s_re), .in_imag(s_im),
    .clear(s_clr), .out_valid(s_ov), .out_ready(s_or), .out_real(s_orl), .out_imag(s_oim),
    .out_overflow(s_oovf), .sample_cnt(s_cnt)
  );

  cplx_frame_accumulator #(.IN_W(16), .ACC_W(24), .FRAME_LEN(1)) u_one (
    .clk(clk), .rst(rst), .in_valid(o_v), .in_ready(o_ir), .in_real(o_re), .in_imag(o_im),
    .clear(o_clr), .out_valid(o_ov), .out_ready(o_or), .out_real(o_orl), .out_imag(o_oim),
    .out_overflow(o_oovf), .sample_cnt(o_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(d_ov), 32'h0);
    chk("rst_cnt", 32'(d_cnt), 32'h0);
    chk("rst_out_real", 32'(d_orl), 32'h0);
    chk("rst_out_ovf", 32'(d_oovf), 32'h0);
    chk("rst_in_ready", 32'(d_ir), 32'h1);
    rst = 1'b0;

    // basic frame
    d_or = 1'b1;
    d_v  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d_re = 16'(i);
      d_im = 16'(10 * i);
      tick();
      if (i == 2) chk("basic_cnt2", 32'(d_cnt), 32'h2);
    end
    d_v = 1'b0;
    chk("basic_valid", 32'(d_ov), 32'h1);
    chk("basic_real", 32'(d_orl), 32'd10);
    chk("basic_imag", 32'(d_oim), 32'd100);
    chk("basic_ovf", 32'(d_oovf), 32'h0);
    chk("basic_cnt_wrap", 32'(d_cnt), 32'h0);
    tick();
    chk("basic_drain", 32'(d_ov), 32'h0);

    // negative wrap
    d_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_re = 16'hFFFF;
      d_im = (i == 0) ? 16'h8000 : 16'h0000;
      tick();
    end
    d_v = 1'b0;
    chk("neg_real", 32'(d_orl), 32'h00FFFFFC);
    chk("neg_imag", 32'(d_oim), 32'h00FF8000);
    tick();

    // backpressure
    d_or = 1'b0;
    d_v  = 1'b1;
    d_re = 16'd1;
    d_im = 16'd0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_f1_valid", 32'(d_ov), 32'h1);
    chk("bp_f1_real", 32'(d_orl), 32'd4);
    d_re = 16'd2;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_cnt3", 32'(d_cnt), 32'd3);
    chk("bp_stall", 32'(d_ir), 32'h0);
    tick();
    chk("bp_hold_cnt", 32'(d_cnt), 32'd3);
    chk("bp_hold_real", 32'(d_orl), 32'd4);
    chk("bp_hold_valid", 32'(d_ov), 32'h1);
    d_or = 1'b1;
    #1;
    chk("bp_release_ready", 32'(d_ir), 32'h1);
    tick();
    chk("bp_f2_valid", 32'(d_ov), 32'h1);
    chk("bp_f2_real", 32'(d_orl), 32'd8);
    for (int i = 0; i < 3; i++) tick();
    d_v = 1'b0;
    chk("bp_f3_cnt", 32'(d_cnt), 32'd3);
    chk("bp_f2_taken", 32'(d_ov), 32'h0);

    // clear
    d_clr = 1'b1;
    tick();
    d_clr = 1'b0;
    chk("clr_idle_cnt", 32'(d_cnt), 32'h0);
    d_v  = 1'b1;
    d_re = 16'd9;
    tick();
    tick();
    chk("clr_pre_cnt", 32'(d_cnt), 32'd2);
    d_clr = 1'b1;
    tick();
    d_clr = 1'b0;
    chk("clr_drop_cnt", 32'(d_cnt), 32'h0);
    d_re = 16'd5;
    for (int i = 0; i < 4; i++) tick();
    d_v = 1'b0;
    chk("clr_valid", 32'(d_ov), 32'h1);
    chk("clr_real", 32'(d_orl), 32'd20);
    tick();

    // async reset mid-frame and during FULL
    d_or = 1'b0;
    d_v  = 1'b1;
    d_re = 16'd1;
    d_im = 16'd2;
    for (int i = 0; i < 6; i++) tick();
    d_v = 1'b0;
    chk("pre_rst_cnt", 32'(d_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(d_ov), 32'h0);
    chk("arst_cnt", 32'(d_cnt), 32'h0);
    chk("arst_real", 32'(d_orl), 32'h0);
    chk("arst_imag", 32'(d_oim), 32'h0);
    #2;
    rst = 1'b0;
    tick();
    d_or = 1'b1;
    d_v  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    d_v = 1'b0;
    chk("post_rst_real", 32'(d_orl), 32'd4);
    chk("post_rst_imag", 32'(d_oim), 32'd8);
    chk("post_rst_valid", 32'(d_ov), 32'h1);

    // saturation at ACC_W=17
    s_or = 1'b1;
    s_v  = 1'b1;
    s_re = 16'd32767;
    for (int i = 0; i < 4; i++) tick();
    chk("sat_real", 32'(s_orl), 32'h0FFFF);
    chk("sat_ovf", 32'(s_oovf), 32'h1);
    s_re = 16'd1;
    for (int i = 0; i < 4; i++) tick();
    s_v = 1'b0;
    chk("sat_next_real", 32'(s_orl), 32'd4);
    chk("sat_next_ovf", 32'(s_oovf), 32'h0);

    // FRAME_LEN = 1
    o_or = 1'b1;
    o_v  = 1'b1;
    o_re = 16'hFFFF;
    o_im = 16'd7;
    tick();
    chk("one_valid", 32'(o_ov), 32'h1);
    chk("one_real", 32'(o_orl), 32'h00FFFFFF);
    chk("one_imag", 32'(o_oim), 32'd7);
    chk("one_cnt", 32'(o_cnt), 32'h0);
    o_re = 16'd5;
    tick();
    o_v = 1'b0;
    chk("one_b2b_real", 32'(o_orl), 32'd5);
    chk("one_b2b_ovf", 32'(o_oovf), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
